dl_rr_arbiter_4p: RTL and testbench

//   Round-robin arbiter that shares one resource between 4 requesters.

---
 rtl/dl_rr_arbiter_4p_pkg.sv | 36 +++
 rtl/dl_rr_arbiter_4p_if.sv | 28 ++
 rtl/dl_rr_arbiter_4p_pri_enc.sv | 26 ++
 rtl/dl_rr_arbiter_4p.sv | 167 ++++++++++++++++
 tb/tb_dl_rr_arbiter_4p.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dl_rr_arbiter_4p_pkg.sv
// Shared types, widths and small helpers for the 4-port round-robin arbiter.
// Optional hold-limit feature is enabled by defining DL_RR_ARB_HOLD_LIMIT_EN.
package dl_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = {NUM_REQ{1'b0}};
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Rotate the request vector so requester (base_id+1)%4 lands on bit 3
  // and base_id itself lands on bit 0 (lowest priority).
  // Bit k therefore carries req[(base_id - k) mod 4].
  function automatic logic [NUM_REQ-1:0] rotate_req(input logic [NUM_REQ-1:0] req,
                                                    input logic [ID_W-1:0]    base_id);
    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    idx;
    rot = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx    = base_id - ID_W'(k);
      rot[k] = req[idx];
    end
    return rot;
  endfunction

endpackage

// File: rtl/dl_rr_arbiter_4p_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface dl_rr_arbiter_4p_if;
  import dl_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic               preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_vld,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_vld,
    output preempt
  );

endinterface

// File: rtl/dl_rr_arbiter_4p_pri_enc.sv
// 4-to-2 priority encoder: the highest set bit wins (bit 3 has top priority).
// o_vld is low when no input bit is set; o_enc is 0 in that case.
module dl_pri_encoder_4p2p (
  input  logic [3:0] i_req,
  output logic [1:0] o_enc,
  output logic       o_vld
);

  logic [1:0] w_enc;

  // Resolve the highest-order asserted request bit.
  always_comb begin
    w_enc = 2'd0;
    casez (i_req)
      4'b1???: w_enc = 2'd3;
      4'b01??: w_enc = 2'd2;
      4'b001?: w_enc = 2'd1;
      4'b0001: w_enc = 2'd0;
      default: w_enc = 2'd0;
    endcase
  end

  assign o_enc = w_enc;
  assign o_vld = |i_req;

endmodule

// File: rtl/dl_rr_arbiter_4p.sv
// Round-robin arbiter sharing one resource among 4 requesters.
// The grant is registered and locked to its owner until the owner drops req;
// release hands over to the next winner on the same edge (no idle bubble).
// Define DL_RR_ARB_HOLD_LIMIT_EN to bound each ownership to HOLD_MAX cycles
// while someone else is waiting; preempt then pulses with the new grant.
module dl_rr_arbiter_4p
  import dl_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
)(
  input  logic                clk,
  input  logic                rst_n,
  dl_rr_arbiter_4p_if.slave   bus
);

  // Elaboration-time guard on the hold limit range.
  if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_range
    $error("dl_rr_arbiter_4p: HOLD_MAX must be within 2..255");
  end

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_gnt_vld;
  logic [ID_W-1:0]     r_last_id;

  logic [ID_W-1:0]     w_base_id;
  logic [NUM_REQ-1:0]  w_rot_req;
  logic [ID_W-1:0]     w_enc;
  logic                w_enc_vld;
  logic [ID_W-1:0]     w_winner;
  logic                w_owner_req;
  logic                w_other_req;
  logic                w_limit_hit;

  // While a grant is active the current owner is the rotation base, so a
  // release or a revoke puts it at lowest priority; when idle, last_id is.
  always_comb begin
    if (r_state == ARB_GRANT) begin
      w_base_id = r_gnt_id;
    end else begin
      w_base_id = r_last_id;
    end
  end

  assign w_rot_req = rotate_req(bus.req, w_base_id);

  dl_pri_encoder_4p2p u_pri_enc (
    .i_req (w_rot_req),
    .o_enc (w_enc),
    .o_vld (w_enc_vld)
  );

  // Map the encoded rotated position back to a requester index:
  // (base+1+(3-enc)) mod 4 == (base - enc) mod 4.
  assign w_winner    = w_base_id - w_enc;
  assign w_owner_req = bus.req[r_gnt_id];
  assign w_other_req = |(bus.req & ~r_gnt);

`ifdef DL_RR_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] r_hold_cnt;
  logic       r_preempt;

  assign w_limit_hit = (r_state == ARB_GRANT) && w_owner_req && w_other_req &&
                       (r_hold_cnt == HOLD_LAST);

  // Count grant cycles of the current owner; restart on every new grant and
  // saturate at the limit when nobody else is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= w_limit_hit;
      case (r_state)
        ARB_IDLE: begin
          r_hold_cnt <= 8'd0;
        end
        ARB_GRANT: begin
          if (!w_owner_req || w_limit_hit) begin
            r_hold_cnt <= 8'd0;
          end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end else begin
            r_hold_cnt <= r_hold_cnt;
          end
        end
        default: begin
          r_hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.preempt = r_preempt;
`else
  assign w_limit_hit = 1'b0;
  assign bus.preempt = 1'b0;
`endif

  // Arbitration FSM: grant on request, lock to owner, hand over or go idle on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= {NUM_REQ{1'b0}};
      r_gnt_id  <= {ID_W{1'b0}};
      r_gnt_vld <= 1'b0;
      r_last_id <= 2'd3;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_enc_vld) begin
            r_state   <= ARB_GRANT;
            r_gnt     <= id_to_onehot(w_winner);
            r_gnt_id  <= w_winner;
            r_gnt_vld <= 1'b1;
          end else begin
            r_state   <= ARB_IDLE;
            r_gnt     <= {NUM_REQ{1'b0}};
            r_gnt_vld <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (!w_owner_req) begin
            // Owner released: its own bit is low, so any remaining request wins.
            r_last_id <= r_gnt_id;
            if (w_enc_vld) begin
              r_state   <= ARB_GRANT;
              r_gnt     <= id_to_onehot(w_winner);
              r_gnt_id  <= w_winner;
              r_gnt_vld <= 1'b1;
            end else begin
              r_state   <= ARB_IDLE;
              r_gnt     <= {NUM_REQ{1'b0}};
              r_gnt_vld <= 1'b0;
            end
          end else if (w_limit_hit) begin
            // Revoke: owner still requests but sits at bit 0, so another requester wins.
            r_last_id <= r_gnt_id;
            r_state   <= ARB_GRANT;
            r_gnt     <= id_to_onehot(w_winner);
            r_gnt_id  <= w_winner;
            r_gnt_vld <= 1'b1;
          end else begin
            r_state   <= ARB_GRANT;
            r_gnt     <= r_gnt;
            r_gnt_id  <= r_gnt_id;
            r_gnt_vld <= r_gnt_vld;
          end
        end
        default: begin
          r_state   <= ARB_IDLE;
          r_gnt     <= {NUM_REQ{1'b0}};
          r_gnt_id  <= {ID_W{1'b0}};
          r_gnt_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_dl_rr_arbiter_4p.sv
// Self-checking bench for dl_rr_arbiter_4p: directed vector table, hand-written
// reset / hold-limit sequences and a long random run against a ring-walking model.
module tb_dl_rr_arbiter_4p;
  import dl_arb_pkg::*;

  localparam int TB_HOLD_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dl_rr_arbiter_4p_if arb_if ();

  dl_rr_arbiter_4p #(.HOLD_MAX(TB_HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner index (-1 when idle), previous owner, cycles held.
  int   m_owner;
  int   m_last;
  int   m_hold;
  bit   m_pre;
  int   wait_cnt [4];
  logic [3:0] prev_gnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // First requester walking the ring after 'base' (base itself is checked last).
  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 1; k <= 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = 3;
    m_hold   = 0;
    m_pre    = 1'b0;
    prev_gnt = 4'b0000;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    m_pre = 1'b0;
    if (m_owner < 0) begin
      m_owner = pick(r, m_last);
      m_hold  = 0;
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = pick(r, m_owner);
      m_hold  = 0;
    end
`ifdef DL_RR_ARB_HOLD_LIMIT_EN
    else if ((m_hold == TB_HOLD_MAX - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
      m_last  = m_owner;
      m_owner = pick(r, m_owner);
      m_pre   = 1'b1;
      m_hold  = 0;
    end else if (m_hold < TB_HOLD_MAX - 1) begin
      m_hold++;
    end
`endif
  endfunction

  task automatic check_model(input logic [3:0] r);
    logic [3:0] eg;
    logic       new_grant;
    int         worst;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    cmp("model_gnt", arb_if.gnt, eg);
    cmp("model_vld", arb_if.gnt_vld, (m_owner >= 0));
    if (m_owner >= 0) cmp("model_gnt_id", arb_if.gnt_id, m_owner[1:0]);
    cmp("model_preempt", arb_if.preempt, m_pre);
    cmp("gnt_onehot", ($countones(arb_if.gnt) <= 1), 1);
    cmp("vld_vs_gnt", arb_if.gnt_vld, (arb_if.gnt != 4'b0000));
    if (arb_if.gnt_vld) cmp("gnt_id_vs_gnt", arb_if.gnt, (4'b0001 << arb_if.gnt_id));
    // Starvation: count new grants to others while a requester keeps waiting.
    new_grant = arb_if.gnt_vld && (arb_if.gnt != prev_gnt);
    worst = 0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i] || arb_if.gnt[i]) wait_cnt[i] = 0;
      else if (new_grant) wait_cnt[i]++;
      if (wait_cnt[i] > worst) worst = wait_cnt[i];
    end
    if (new_grant) cmp("starvation_le3", (worst <= 3), 1);
    prev_gnt = arb_if.gnt;
  endtask

  // Called at a negedge: drive req, let one posedge happen, check at next negedge.
  task automatic step(input logic [3:0] r);
    arb_if.req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_model(r);
  endtask

  task automatic do_reset();
    arb_if.req = 4'b0000;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("rst_gnt", arb_if.gnt, 4'b0000);
    cmp("rst_gnt_id", arb_if.gnt_id, 2'd0);
    cmp("rst_vld", arb_if.gnt_vld, 1'b0);
    cmp("rst_preempt", arb_if.preempt, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       vld;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [3:0] r;
    arb_if.req = 4'b0000;
    model_reset();

    // Scenario 1: full request after reset, zero-bubble handover.
    vecs.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 4'b1110, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1110, 4'b0010, 1'b1});
    // Scenario 2: req=1010, owners drop for one cycle after 3 grant cycles.
    vecs.push_back('{1'b1, 4'b1010, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1000, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b1010, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b1010, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b1});
    vecs.push_back('{1'b0, 4'b1000, 4'b1000, 1'b1});
    // Scenario 3: single pulse on req[2], idle, then last_id=2 favours requester 3.
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].req);
      cmp($sformatf("vec%0d_gnt", i), arb_if.gnt, vecs[i].gnt);
      cmp($sformatf("vec%0d_vld", i), arb_if.gnt_vld, vecs[i].vld);
      if (vecs[i].vld) cmp($sformatf("vec%0d_gnt_id", i), arb_if.gnt_id, $clog2(vecs[i].gnt));
    end

    // Scenario 4: asynchronous reset while requester 3 owns the grant.
    do_reset();
    step(4'b1000);
    cmp("pre_async_gnt", arb_if.gnt, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_gnt", arb_if.gnt, 4'b0000);
    cmp("async_rst_vld", arb_if.gnt_vld, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b1001);
    cmp("post_async_gnt", arb_if.gnt, 4'b0001);

`ifdef DL_RR_ARB_HOLD_LIMIT_EN
    // Scenario 5: hold limit revokes requester 0 in favour of requester 1.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(4'b0011);
      cmp($sformatf("hold_gnt0_c%0d", c), arb_if.gnt, 4'b0001);
      cmp($sformatf("hold_pre0_c%0d", c), arb_if.preempt, 1'b0);
    end
    step(4'b0011);
    cmp("revoke_gnt", arb_if.gnt, 4'b0010);
    cmp("revoke_preempt", arb_if.preempt, 1'b1);
    step(4'b0011);
    cmp("after_revoke_preempt", arb_if.preempt, 1'b0);
    cmp("after_revoke_gnt", arb_if.gnt, 4'b0010);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(4'b0001);
      cmp("alone_gnt", arb_if.gnt, 4'b0001);
      cmp("alone_preempt", arb_if.preempt, 1'b0);
    end
`endif

    // Scenario 6: random traffic; waiters keep req high, owners release at random.
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (arb_if.gnt[i])  r[i] = ($urandom_range(3) != 0);
        else if (r[i])      r[i] = ($urandom_range(15) != 0);
        else                r[i] = ($urandom_range(2) == 0);
      end
      if ((c % 500) == 499) r = 4'($urandom_range(15));
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
